// File: rtl/vgpr_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vgpr_rd_port_arbiter
// Description : Round-robin arbiter sharing one VGPR bank read port between
//               port0 (ALU operand fetch) and port1 (LSU store-data fetch).
//               Optional macro: VGPR_RD_ARB_CONFLICT_CNT_EN (conflict counter).
// Revision    : 1.0 - initial release
// ============================================================================
module vgpr_rd_port_arbiter #(
    parameter int DATAWIDTH  = 2048,
    parameter int ADDRWIDTH  = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 port0_rd_req,
    input  logic [ADDRWIDTH-1:0] port0_rd_addr,
    output logic                 port0_rd_gnt,
    output logic                 port0_rd_valid,
    input  logic                 port1_rd_req,
    input  logic [ADDRWIDTH-1:0] port1_rd_addr,
    output logic                 port1_rd_gnt,
    output logic                 port1_rd_valid,
    output logic [DATAWIDTH-1:0] port_rd_data,
    output logic                 bank_rd_en,
    output logic [ADDRWIDTH-1:0] bank_rd_addr,
    input  logic [DATAWIDTH-1:0] bank_rd_data,
    output logic [15:0]          arb_conflict_cnt
);

    localparam int c_tag_last = RD_LATENCY - 1;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  last_winner_q, last_winner_d;
    logic                  bank_rd_en_q, bank_rd_en_d;
    logic [ADDRWIDTH-1:0]  bank_rd_addr_q, bank_rd_addr_d;
    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_port_q, tag_port_d;
    logic                  port0_rd_valid_q, port0_rd_valid_d;
    logic                  port1_rd_valid_q, port1_rd_valid_d;

    // last_winner_q=1 means port1 won last, so port0 takes the next tie.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (port0_rd_req && port1_rd_req) begin
            w_gnt0 = last_winner_q;
            w_gnt1 = ~last_winner_q;
        end else begin
            w_gnt0 = port0_rd_req;
            w_gnt1 = port1_rd_req;
        end
    end

    always_comb begin
        last_winner_d  = last_winner_q;
        bank_rd_en_d   = w_gnt0 | w_gnt1;
        bank_rd_addr_d = bank_rd_addr_q;
        if (w_gnt0) begin
            last_winner_d  = 1'b0;
            bank_rd_addr_d = port0_rd_addr;
        end else if (w_gnt1) begin
            last_winner_d  = 1'b1;
            bank_rd_addr_d = port1_rd_addr;
        end
    end

    // Stage 0 is loaded together with bank_rd_en; the valid flop after the
    // last stage lines the tag up with bank data RD_LATENCY cycles later.
    always_comb begin
        tag_vld_d     = '0;
        tag_port_d    = '0;
        tag_vld_d[0]  = w_gnt0 | w_gnt1;
        tag_port_d[0] = w_gnt1;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_port_d[i] = tag_port_q[i-1];
        end
        port0_rd_valid_d = tag_vld_q[c_tag_last] & ~tag_port_q[c_tag_last];
        port1_rd_valid_d = tag_vld_q[c_tag_last] &  tag_port_q[c_tag_last];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_q    <= 1'b1;
            bank_rd_en_q     <= 1'b0;
            bank_rd_addr_q   <= '0;
            tag_vld_q        <= '0;
            tag_port_q       <= '0;
            port0_rd_valid_q <= 1'b0;
            port1_rd_valid_q <= 1'b0;
        end else begin
            last_winner_q    <= last_winner_d;
            bank_rd_en_q     <= bank_rd_en_d;
            bank_rd_addr_q   <= bank_rd_addr_d;
            tag_vld_q        <= tag_vld_d;
            tag_port_q       <= tag_port_d;
            port0_rd_valid_q <= port0_rd_valid_d;
            port1_rd_valid_q <= port1_rd_valid_d;
        end
    end

`ifdef VGPR_RD_ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (port0_rd_req && port1_rd_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign arb_conflict_cnt = conflict_cnt_q;
`else
    assign arb_conflict_cnt = 16'd0;
`endif

    assign port0_rd_gnt   = w_gnt0;
    assign port1_rd_gnt   = w_gnt1;
    assign port0_rd_valid = port0_rd_valid_q;
    assign port1_rd_valid = port1_rd_valid_q;
    assign bank_rd_en     = bank_rd_en_q;
    assign bank_rd_addr   = bank_rd_addr_q;
    assign port_rd_data   = bank_rd_data;

endmodule
`default_nettype wire
